// File: rtl/multi_debounce_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce_fsm_if
// Brief    : Bus bundle between raw-pin debouncer and its control-side user.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_debounce_fsm_if #(
  parameter int NUM_CHANNELS           = 8,
  parameter int DEBOUNCE_COUNTER_WIDTH = 16
);
  logic [DEBOUNCE_COUNTER_WIDTH-1:0] i_debounce_counter;
  logic [NUM_CHANNELS-1:0]           i_bouncing_signal;
  logic [NUM_CHANNELS-1:0]           o_debounced_signal;
  logic [NUM_CHANNELS-1:0]           o_rise_pulse;
  logic [NUM_CHANNELS-1:0]           o_fall_pulse;
  logic [NUM_CHANNELS-1:0]           o_busy;

  modport master (
    output i_debounce_counter,
    output i_bouncing_signal,
    input  o_debounced_signal,
    input  o_rise_pulse,
    input  o_fall_pulse,
    input  o_busy
  );

  modport slave (
    input  i_debounce_counter,
    input  i_bouncing_signal,
    output o_debounced_signal,
    output o_rise_pulse,
    output o_fall_pulse,
    output o_busy
  );
endinterface
`default_nettype wire

// File: rtl/multi_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multi_debounce_fsm
// Brief    : NUM_CHANNELS independent debounce FSMs sharing one live limit K.
//            Edge pulses exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module multi_debounce_fsm #(
  parameter int   NUM_CHANNELS           = 8,
  parameter int   DEBOUNCE_COUNTER_WIDTH = 16,
  parameter int   SYNC_STAGES            = 2,
  parameter logic RESET_LEVEL            = 1'b0
) (
  input  wire logic           i_clock,
  input  wire logic           i_reset,
  multi_debounce_fsm_if.slave dbn_if
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    STABLE_HIGH = 2'd1,
    SETTLING    = 2'd2
  } state_e;

  localparam logic [DEBOUNCE_COUNTER_WIDTH-1:0] C_CNT_MAX = '1;
  localparam state_e C_RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  logic [NUM_CHANNELS-1:0] w_debounced;
  logic [NUM_CHANNELS-1:0] w_rise;
  logic [NUM_CHANNELS-1:0] w_fall;
  logic [NUM_CHANNELS-1:0] w_busy;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
    logic [SYNC_STAGES-1:0]            sync_q;
    logic                              w_s;
    state_e                            state_q, state_d;
    logic [DEBOUNCE_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                              lvl_q, lvl_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], dbn_if.i_bouncing_signal[ch]};
      end
    end

    assign w_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        state_q <= C_RESET_STATE;
        cnt_q   <= '0;
        lvl_q   <= RESET_LEVEL;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
      end
    end

    // Limit is compared with >= so a lowered K finishes an ongoing settle at once.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      case (state_q)
        STABLE_LOW, STABLE_HIGH: begin
          if (w_s != lvl_q) begin
            state_d = SETTLING;
            cnt_d   = '0;
          end
        end
        SETTLING: begin
          if (w_s == lvl_q) begin
            state_d = lvl_q ? STABLE_HIGH : STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q >= dbn_if.i_debounce_counter) begin
            state_d = w_s ? STABLE_HIGH : STABLE_LOW;
            lvl_d   = w_s;
            cnt_d   = '0;
          end else if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = lvl_q ? STABLE_HIGH : STABLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end

    assign w_debounced[ch] = lvl_q;
    assign w_busy[ch]      = (state_q == SETTLING);

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q;
    logic fall_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= lvl_d & ~lvl_q;
        fall_q <= ~lvl_d & lvl_q;
      end
    end

    assign w_rise[ch] = rise_q;
    assign w_fall[ch] = fall_q;
`else
    assign w_rise[ch] = 1'b0;
    assign w_fall[ch] = 1'b0;
`endif
  end

  assign dbn_if.o_debounced_signal = w_debounced;
  assign dbn_if.o_rise_pulse       = w_rise;
  assign dbn_if.o_fall_pulse       = w_fall;
  assign dbn_if.o_busy             = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_debounce_fsm
// Brief    : Scoreboard bench for multi_debounce_fsm with a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_debounce_fsm;
  localparam int   N  = 4;
  localparam int   W  = 16;
  localparam int   S  = 2;
  localparam logic RL = 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] deb;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] busy;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  int           k_val = 10;
  int           total = 0;
  int           bad = 0;
  obs_t         sb[$];

  always #5 clk = ~clk;

  multi_debounce_fsm_if #(.NUM_CHANNELS(N), .DEBOUNCE_COUNTER_WIDTH(W)) dbn ();

  assign dbn.i_debounce_counter = W'(k_val);
  assign dbn.i_bouncing_signal  = raw;

  multi_debounce_fsm #(
    .NUM_CHANNELS(N),
    .DEBOUNCE_COUNTER_WIDTH(W),
    .SYNC_STAGES(S),
    .RESET_LEVEL(RL)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .dbn_if (dbn)
  );

  function automatic void check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference: a channel flips once s has differed from its level on K+2 edges in a row.
  logic [N-1:0] m_lvl;
  int           m_run[N];
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_s;
  obs_t         m_e;

  task automatic m_reset();
    m_lvl = {N{RL}};
    for (int c = 0; c < N; c++) m_run[c] = 0;
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back({N{RL}});
    sb.delete();
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
        if (clk) begin
          m_e = '0;
          m_e.deb = {N{RL}};
          sb.push_back(m_e);
        end
      end else begin
        m_s = m_hist.pop_front();
        m_hist.push_back(raw);
        m_e = '0;
        for (int c = 0; c < N; c++) begin
          if (m_s[c] !== m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] >= 2 && (m_run[c] - 2) >= k_val) begin
              m_lvl[c] = m_s[c];
              m_run[c] = 0;
              if (PULSE_EN) begin
                if (m_s[c]) m_e.rise[c] = 1'b1;
                else        m_e.fall[c] = 1'b1;
              end
            end
          end else begin
            m_run[c] = 0;
          end
          m_e.busy[c] = (m_run[c] >= 1);
        end
        m_e.deb = m_lvl;
        sb.push_back(m_e);
      end
    end
  end

  obs_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sb_deb",  dbn.o_debounced_signal, mon_e.deb);
        check("sb_rise", dbn.o_rise_pulse,       mon_e.rise);
        check("sb_fall", dbn.o_fall_pulse,       mon_e.fall);
        check("sb_busy", dbn.o_busy,             mon_e.busy);
      end
    end
  end

  task automatic wait_flip(input int ch, input logic val, input int exp_edges, input string name);
    int n = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (dbn.o_debounced_signal[ch] === val) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || n != exp_edges) begin
      bad++;
      $display("FAIL %s edges actual=%0d required=%0d", name, n, exp_edges);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_deb",  dbn.o_debounced_signal, {N{RL}});
    check("reset_rise", dbn.o_rise_pulse, '0);
    check("reset_fall", dbn.o_fall_pulse, '0);
    check("reset_busy", dbn.o_busy, '0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean rise on ch0
    raw[0] = 1'b1;
    wait_flip(0, 1'b1, S + 10 + 2, "clean_rise");
    check("clean_rise_pulse", dbn.o_rise_pulse, PULSE_EN ? 4'b0001 : 4'b0000);
    repeat (3) @(negedge clk);

    // Glitch on ch1
    raw[1] = 1'b1;
    repeat (5) @(negedge clk);
    raw[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_deb", dbn.o_debounced_signal, 4'b0001);

    // K = 0 on ch2
    k_val = 0;
    raw[2] = 1'b1;
    wait_flip(2, 1'b1, 4, "k0_rise");
    @(negedge clk) raw[2] = 1'b0;
    wait_flip(2, 1'b0, 4, "k0_fall");
    check("k0_fall_pulse", dbn.o_fall_pulse, PULSE_EN ? 4'b0100 : 4'b0000);
    @(negedge clk) raw[2] = 1'b1;
    wait_flip(2, 1'b1, 4, "k0_rise2");

    // Simultaneous ch2 fall and ch3 rise
    @(negedge clk);
    k_val = 10;
    raw[2] = 1'b0;
    raw[3] = 1'b1;
    wait_flip(3, 1'b1, 14, "simul");
    check("simul_deb",  dbn.o_debounced_signal, 4'b1001);
    check("simul_rise", dbn.o_rise_pulse, PULSE_EN ? 4'b1000 : 4'b0000);
    check("simul_fall", dbn.o_fall_pulse, PULSE_EN ? 4'b0100 : 4'b0000);

    // Live limit: settle ch0 to counter 20 under K=1000, then drop K
    @(negedge clk);
    k_val = 1000;
    raw[0] = 1'b0;
    repeat (23) @(negedge clk);
    check("live_busy", dbn.o_busy, 4'b0001);
    k_val = 5;
    wait_flip(0, 1'b0, 1, "live_limit");

    // Reset mid-settle on ch1
    @(negedge clk);
    k_val = 10;
    raw[1] = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_deb",  dbn.o_debounced_signal, '0);
    check("async_rst_busy", dbn.o_busy, '0);
    check("async_rst_rise", dbn.o_rise_pulse, '0);
    check("async_rst_fall", dbn.o_fall_pulse, '0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    wait_flip(1, 1'b1, 14, "re_debounce");

    // Randomized traffic
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) k_val = $urandom_range(0, 6);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) raw[c] = ~raw[c];
      end
    end
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
